// File: rtl/paddle_pkg.sv
// Shared constants and helper functions for the paddle axis front end.
package paddle_pkg;

    // Field positions inside the hps_io mouse packet.
    localparam int MS_STB   = 24;
    localparam int MS_XS    = 4;
    localparam int MS_YS    = 5;
    localparam int MS_DX_LO = 8;
    localparam int MS_DY_LO = 16;

    // Limit a scaled mouse delta to the symmetric range [-max, +max].
    function automatic int clamp_step(input int d, input int max);
        if (d > max) begin
            return max;
        end
        if (d < -max) begin
            return -max;
        end
        return d;
    endfunction

    // Bring an accumulator sum back into a w-bit signed range, either by
    // saturating at the rails or by keeping the low w bits (spinner mode).
    function automatic int sat_or_wrap(input int sum, input logic wrap, input int w);
        int hi;
        int lo;
        int m;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (wrap) begin
            m = sum & ((1 << w) - 1);
            if (m > hi) begin
                m = m - (1 << w);
            end
            return m;
        end
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/paddle_axis_acc.sv
// One mouse axis: scale and clamp the packet delta into a step register,
// then fold the step into a saturating or wrapping position accumulator.
module paddle_axis_acc
    import paddle_pkg::*;
#(
    parameter int AXIS_W     = 8,
    parameter int MAX_STEP   = 10,
    parameter int SENS_SHIFT = 1
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     detect_i,
    input  logic                     sign_i,
    input  logic [7:0]               delta_i,
    input  logic                     wrap_i,
    input  logic                     clear_i,
    output logic signed [AXIS_W-1:0] acc_o,
    output logic                     stepValid_o
);

    logic signed [8:0]        delta9;
    logic signed [8:0]        scaled;
    logic signed [AXIS_W-1:0] step_d;
    logic signed [AXIS_W-1:0] step_q;
    logic                     stepValid_q;
    logic signed [AXIS_W+1:0] sum;
    logic signed [AXIS_W-1:0] acc_d;
    logic signed [AXIS_W-1:0] acc_q;

    assign delta9 = {sign_i, delta_i};
    assign scaled = delta9 >>> SENS_SHIFT;
    assign sum    = {{2{acc_q[AXIS_W-1]}}, acc_q} + {{2{step_q[AXIS_W-1]}}, step_q};

    // Sensitivity scaling and step clamp for the incoming delta.
    always_comb begin
        step_d = AXIS_W'(clamp_step(int'(scaled), MAX_STEP));
    end

    // Step register: captures one clamped step per strobe toggle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            step_q      <= '0;
            stepValid_q <= 1'b0;
        end else begin
            stepValid_q <= detect_i;
            if (detect_i) begin
                step_q <= step_d;
            end
        end
    end

    // Next accumulator value; a clear wins over a pending step.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (stepValid_q) begin
            acc_d = AXIS_W'(sat_or_wrap(int'(sum), wrap_i, AXIS_W));
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o       = acc_q;
    assign stepValid_o = stepValid_q;

endmodule

// File: rtl/paddle_axis_mux.sv
// Mouse / analog-stick to paddle front end: strobe detection, ownership
// arbitration between mouse and stick, and the registered output mux.
module paddle_axis_mux
    import paddle_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int MOUSE_PLAYER = 0,
    parameter int AXIS_W       = 8,
    parameter int MAX_STEP     = 10,
    parameter int SENS_SHIFT   = 1
) (
    input  logic                              clk_sys,
    input  logic                              reset_n,
    input  logic [24:0]                       ps2_mouse,
    input  logic [16*NUM_PLAYERS-1:0]         joya,
    input  logic [2*NUM_PLAYERS-1:0]          joy_btn,
    input  logic                              wrap_mode,
    input  logic                              recentre,
    output logic [2*AXIS_W*NUM_PLAYERS-1:0]   paddle,
    output logic [2*NUM_PLAYERS-1:0]          paddle_btn,
    output logic                              mouse_active
);

    logic                            armed_q;
    logic                            oldStb_q;
    logic                            detect;
    logic                            stickOwn;
    logic                            clearAcc;
    logic signed [AXIS_W-1:0]        accX;
    logic signed [AXIS_W-1:0]        accY;
    logic                            stepValid;
    logic                            unusedValidY;
    logic                            unusedMouseBits;
    logic                            mouseActive_d;
    logic                            mouseActive_q;
    logic [2*AXIS_W*NUM_PLAYERS-1:0] paddle_d;
    logic [2*AXIS_W*NUM_PLAYERS-1:0] paddle_q;
    logic [2*NUM_PLAYERS-1:0]        paddleBtn_d;
    logic [2*NUM_PLAYERS-1:0]        paddleBtn_q;

    assign unusedMouseBits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

    // The first edge after reset only samples the strobe level, so a held
    // strobe never looks like a toggle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_q  <= 1'b0;
            oldStb_q <= 1'b0;
        end else begin
            armed_q  <= 1'b1;
            oldStb_q <= ps2_mouse[MS_STB];
        end
    end

    assign detect   = armed_q && (ps2_mouse[MS_STB] != oldStb_q);
    assign stickOwn = |joya[16*MOUSE_PLAYER +: 16];
    assign clearAcc = stickOwn || recentre;

    paddle_axis_acc #(
        .AXIS_W     (AXIS_W),
        .MAX_STEP   (MAX_STEP),
        .SENS_SHIFT (SENS_SHIFT)
    ) u_accX (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .detect_i    (detect),
        .sign_i      (ps2_mouse[MS_XS]),
        .delta_i     (ps2_mouse[MS_DX_LO +: 8]),
        .wrap_i      (wrap_mode),
        .clear_i     (clearAcc),
        .acc_o       (accX),
        .stepValid_o (stepValid)
    );

    paddle_axis_acc #(
        .AXIS_W     (AXIS_W),
        .MAX_STEP   (MAX_STEP),
        .SENS_SHIFT (SENS_SHIFT)
    ) u_accY (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .detect_i    (detect),
        .sign_i      (ps2_mouse[MS_YS]),
        .delta_i     (ps2_mouse[MS_DY_LO +: 8]),
        .wrap_i      (wrap_mode),
        .clear_i     (clearAcc),
        .acc_o       (accY),
        .stepValid_o (unusedValidY)
    );

    // Ownership: a live stick always wins; recentre leaves ownership alone;
    // otherwise any applied mouse step hands the player back to the mouse.
    always_comb begin
        mouseActive_d = mouseActive_q;
        if (stickOwn) begin
            mouseActive_d = 1'b0;
        end else if (!recentre && stepValid) begin
            mouseActive_d = 1'b1;
        end
    end

    // Output mux: sticks pass through for every player, the mouse replaces
    // its player while it owns it.
    always_comb begin
        paddle_d    = '0;
        paddleBtn_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            paddle_d[2*AXIS_W*p +: AXIS_W]          = AXIS_W'(signed'(joya[16*p +: 8]));
            paddle_d[2*AXIS_W*p + AXIS_W +: AXIS_W] = AXIS_W'(signed'(joya[16*p + 8 +: 8]));
            paddleBtn_d[2*p +: 2]                   = joy_btn[2*p +: 2];
        end
        if (mouseActive_q) begin
            paddle_d[2*AXIS_W*MOUSE_PLAYER +: 2*AXIS_W] = {accY, accX};
            paddleBtn_d[2*MOUSE_PLAYER +: 2]            = ps2_mouse[1:0];
        end
    end

    // Registered outputs and ownership flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            paddle_q      <= '0;
            paddleBtn_q   <= '0;
            mouseActive_q <= 1'b0;
        end else begin
            paddle_q      <= paddle_d;
            paddleBtn_q   <= paddleBtn_d;
            mouseActive_q <= mouseActive_d;
        end
    end

    assign paddle       = paddle_q;
    assign paddle_btn   = paddleBtn_q;
    assign mouse_active = mouseActive_q;

endmodule

// File: tb/tb_paddle_axis_mux.sv
// Scoreboard bench for paddle_axis_mux: stimulus queues expected outputs
// tagged with the cycle they must appear in; a negedge monitor checks them.
module tb_paddle_axis_mux;

    typedef struct {
        int          cyc;
        bit          sens0;
        logic [31:0] paddle;
        logic [3:0]  btn;
        logic        active;
        string       name;
    } sbEntry_t;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [24:0] ps2_mouse;
    logic [31:0] joya;
    logic [3:0]  joy_btn;
    logic        wrap_mode;
    logic        recentre;
    logic [31:0] paddle;
    logic [3:0]  paddle_btn;
    logic        mouse_active;
    logic [31:0] paddleS0;
    logic [3:0]  paddleBtnS0;
    logic        mouseActiveS0;

    sbEntry_t sbQ[$];
    int       cyc     = 0;
    int       nChecks = 0;
    int       nFails  = 0;
    logic     stb     = 1'b0;

    paddle_axis_mux #(
        .NUM_PLAYERS(2), .MOUSE_PLAYER(0), .AXIS_W(8), .MAX_STEP(10), .SENS_SHIFT(1)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .joya(joya),
        .joy_btn(joy_btn), .wrap_mode(wrap_mode), .recentre(recentre),
        .paddle(paddle), .paddle_btn(paddle_btn), .mouse_active(mouse_active)
    );

    paddle_axis_mux #(
        .NUM_PLAYERS(2), .MOUSE_PLAYER(0), .AXIS_W(8), .MAX_STEP(10), .SENS_SHIFT(0)
    ) dutS0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .joya(joya),
        .joy_btn(joy_btn), .wrap_mode(wrap_mode), .recentre(recentre),
        .paddle(paddleS0), .paddle_btn(paddleBtnS0), .mouse_active(mouseActiveS0)
    );

    initial forever #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc++;

    // Keep the scoreboard ordered by the cycle each expectation is due.
    function automatic void push(input sbEntry_t e);
        int i = 0;
        while (i < sbQ.size() && sbQ[i].cyc <= e.cyc) i++;
        sbQ.insert(i, e);
    endfunction

    function automatic void expRaw(input int at, input logic [31:0] p, input logic [3:0] b,
                                   input logic a, input string nm);
        sbEntry_t e;
        e.cyc = at; e.sens0 = 1'b0; e.paddle = p; e.btn = b; e.active = a; e.name = nm;
        push(e);
    endfunction

    // Player 1 always shows its stick {0xFE,0x03}, buttons 2'b10.
    function automatic void expMouse(input int off, input logic [7:0] y, input logic [7:0] x,
                                     input logic a, input string nm);
        expRaw(cyc + off, {16'hFE03, y, x}, 4'b1010, a, nm);
    endfunction

    function automatic void expStick(input int off, input logic [7:0] y, input logic [7:0] x,
                                     input logic a, input string nm);
        expRaw(cyc + off, {16'hFE03, y, x}, 4'b1001, a, nm);
    endfunction

    function automatic void expS0(input int off, input logic [7:0] x, input string nm);
        sbEntry_t e;
        e.cyc = cyc + off; e.sens0 = 1'b1; e.paddle = {24'h0, x}; e.btn = '0;
        e.active = 1'b0; e.name = nm;
        push(e);
    endfunction

    task automatic checkOutput(input sbEntry_t e);
        nChecks++;
        if (e.cyc < cyc) begin
            nFails++;
            $display("[TB] FAIL %s: slot cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
        end else if (e.sens0) begin
            if (paddleS0[7:0] !== e.paddle[7:0]) begin
                nFails++;
                $display("[TB] FAIL %s: x got %h expected %h", e.name, paddleS0[7:0], e.paddle[7:0]);
            end
        end else if (paddle !== e.paddle || paddle_btn !== e.btn || mouse_active !== e.active) begin
            nFails++;
            $display("[TB] FAIL %s: got paddle=%h btn=%b active=%b expected paddle=%h btn=%b active=%b",
                     e.name, paddle, paddle_btn, mouse_active, e.paddle, e.btn, e.active);
        end
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk_sys) begin
        while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
            checkOutput(sbQ.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    // Present a new mouse packet with the strobe toggled; buttons fixed at 2'b10.
    task automatic applyStimulus(input logic [7:0] dx, input logic xs,
                                 input logic [7:0] dy, input logic ys);
        stb       = ~stb;
        ps2_mouse = {stb, dy, dx, 2'b00, ys, xs, 2'b00, 2'b10};
    endtask

    initial begin
        int waitCycles;
        reset_n   = 1'b0;
        ps2_mouse = '0;
        joya      = {16'hFE03, 16'h0000};
        joy_btn   = 4'b1001;
        wrap_mode = 1'b0;
        recentre  = 1'b0;

        expRaw(1, 32'h0, 4'b0000, 1'b0, "reset_state");
        expRaw(3, 32'h0, 4'b0000, 1'b0, "reset_held");
        repeat (3) tick();
        reset_n = 1'b1;
        expStick(1, 8'h00, 8'h00, 1'b0, "idle_stick");
        tick();

        // First step: dx=40 -> 20 -> clamped 10; dy=6 -> 3.
        applyStimulus(8'h28, 1'b0, 8'h06, 1'b0);
        expStick(2, 8'h00, 8'h00, 1'b1, "t1_active_before_paddle");
        expMouse(3, 8'h03, 8'h0A, 1'b1, "t1_first_step");
        tick();

        // Saturating run, one toggle per cycle.
        for (int i = 1; i <= 13; i++) begin
            int xv;
            xv = 10 + 10 * i;
            if (xv > 127) xv = 127;
            applyStimulus(8'h28, 1'b0, 8'h00, 1'b0);
            expMouse(3, 8'h03, xv[7:0], 1'b1, $sformatf("t2_sat_%0d", i));
            tick();
        end
        settle();
        expMouse(1, 8'h03, 8'h7F, 1'b1, "t2_hold");
        tick();

        // Recentre, climb to 120, then wrap past the top.
        recentre = 1'b1;
        expMouse(2, 8'h00, 8'h00, 1'b1, "t3_recentre");
        tick();
        recentre = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(8'h28, 1'b0, 8'h00, 1'b0);
            if (i == 12) expMouse(3, 8'h00, 8'h78, 1'b1, "t3_reach_120");
            tick();
        end
        settle();
        wrap_mode = 1'b1;
        applyStimulus(8'h28, 1'b0, 8'h00, 1'b0);
        expMouse(3, 8'h00, 8'h82, 1'b1, "t3_wrap_1");
        tick();
        applyStimulus(8'h28, 1'b0, 8'h00, 1'b0);
        expMouse(3, 8'h00, 8'h8C, 1'b1, "t3_wrap_2");
        tick();
        settle();
        wrap_mode = 1'b0;

        // Negative deltas and the negative clamp.
        recentre = 1'b1;
        tick();
        recentre = 1'b0;
        applyStimulus(8'hF0, 1'b1, 8'h00, 1'b0);
        expMouse(3, 8'h00, 8'hF8, 1'b1, "t4_neg_step");
        expS0(3, 8'hF6, "t4_s0_neg16_clamp");
        tick();
        settle();
        recentre = 1'b1;
        tick();
        recentre = 1'b0;
        applyStimulus(8'h80, 1'b1, 8'h00, 1'b0);
        expMouse(3, 8'h00, 8'hF6, 1'b1, "t4_neg64_clamp");
        expS0(3, 8'hF6, "t4_s0_neg128_clamp");
        tick();
        settle();

        // Stick takeover arriving with a toggle in the same cycle.
        joya = {16'hFE03, 16'h0005};
        applyStimulus(8'h28, 1'b0, 8'h00, 1'b0);
        expMouse(1, 8'h00, 8'hF6, 1'b0, "t5_takeover_edge");
        expStick(2, 8'h00, 8'h05, 1'b0, "t5_stick_owns");
        repeat (3) tick();
        joya = {16'hFE03, 16'h0000};
        expStick(1, 8'h00, 8'h00, 1'b0, "t5_stick_released");
        tick();
        applyStimulus(8'h28, 1'b0, 8'h00, 1'b0);
        expMouse(3, 8'h00, 8'h0A, 1'b1, "t5_mouse_reclaims");
        tick();
        settle();

        // Reset with a step in flight, released with the strobe held high.
        applyStimulus(8'h28, 1'b0, 8'h00, 1'b0);
        tick();
        reset_n = 1'b0;
        expRaw(cyc, 32'h0, 4'b0000, 1'b0, "t6_async_reset");
        stb       = 1'b1;
        ps2_mouse = {stb, 8'h00, 8'h28, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10};
        repeat (3) tick();
        reset_n = 1'b1;
        expStick(3, 8'h00, 8'h00, 1'b0, "t6_no_spurious_a");
        expStick(4, 8'h00, 8'h00, 1'b0, "t6_no_spurious_b");
        repeat (4) tick();
        applyStimulus(8'h28, 1'b0, 8'h00, 1'b0);
        expMouse(3, 8'h00, 8'h0A, 1'b1, "t6_first_real_step");
        tick();

        waitCycles = 0;
        while (sbQ.size() > 0 && waitCycles < 100) begin
            tick();
            waitCycles++;
        end
        if (sbQ.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
